// File: rtl/exec_pkg.sv
// Shared types and constants for the 24-bit execute stage.
package exec_pkg;

   localparam int W        = 24;
   localparam int BUNDLE_W = 147;
   localparam int EX_MEM_W = 55;

   // ID/EX bundle field positions (LSB of each field)
   localparam int PC_LSB         = 123;
   localparam int OPTYPE_LSB     = 121;
   localparam int OPCODE_LSB     = 117;
   localparam int IMM_SRC_BIT    = 116;
   localparam int BRANCH_BIT     = 115;
   localparam int MEM_WRITE_BIT  = 114;
   localparam int MEM_TO_REG_BIT = 113;
   localparam int REG_WRITE_BIT  = 112;
   localparam int ALU_CTRL_LSB   = 108;
   localparam int RA_LSB         = 104;
   localparam int RD1_LSB        = 80;
   localparam int RB_LSB         = 76;
   localparam int RD2_LSB        = 52;
   localparam int RC_LSB         = 48;
   localparam int RD3_LSB        = 24;
   localparam int IMM_LSB        = 0;

   typedef enum logic [3:0] {
      ALU_ADD   = 4'd0,
      ALU_SUB   = 4'd1,
      ALU_AND   = 4'd2,
      ALU_OR    = 4'd3,
      ALU_XOR   = 4'd4,
      ALU_SLL   = 4'd5,
      ALU_SRL   = 4'd6,
      ALU_MUL   = 4'd7,
      ALU_PASSB = 4'd8
   } alu_op_t;

   typedef enum logic {
      ST_IDLE = 1'b0,
      ST_MUL  = 1'b1
   } mul_state_t;

   typedef struct packed {
      logic         mem_write;
      logic         mem_to_reg;
      logic         reg_write;
      logic [3:0]   rc;
      logic [W-1:0] alu_result;
      logic [W-1:0] store_data;
   } ex_mem_t;

endpackage

// File: rtl/execute_stage_if.sv
// Decode-to-execute bus: ID/EX bundle, forwarding inputs, EX/MEM results.
interface execute_stage_if
   import exec_pkg::*;
#(
   parameter int W = 24
);
   logic                en;
   logic [BUNDLE_W-1:0] bufferIn;
   logic [1:0]          fwdSel1;
   logic [1:0]          fwdSel2;
   logic [1:0]          fwdSel3;
   logic [W-1:0]        fwdMem;
   logic [W-1:0]        fwdWb;
   logic                flush;
   logic                stall;
   logic                branchTaken;
   logic [W-1:0]        branchTarget;
   logic [EX_MEM_W-1:0] exMemOut;

   modport master (
      output en, bufferIn, fwdSel1, fwdSel2, fwdSel3, fwdMem, fwdWb, flush,
      input  stall, branchTaken, branchTarget, exMemOut
   );

   modport slave (
      input  en, bufferIn, fwdSel1, fwdSel2, fwdSel3, fwdMem, fwdWb, flush,
      output stall, branchTaken, branchTarget, exMemOut
   );
endinterface

// File: rtl/shift_add_multiplier.sv
// Iterative shift-add multiplier: one partial-product step per enabled clock.
//
//  state   | meaning
//  --------+-------------------------------------------------
//  ST_IDLE | waiting for start; operands load on start
//  ST_MUL  | iterating; done on the step where cnt == last
module shift_add_multiplier
   import exec_pkg::*;
#(
   parameter int W          = 24,
   parameter int MUL_CYCLES = W
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         en,
   input  logic         start,
   input  logic         abort,
   input  logic [W-1:0] a,
   input  logic [W-1:0] b,
   output logic         busy,
   output logic         done,
   output logic [W-1:0] product
);
   localparam int                CNT_W = $clog2(MUL_CYCLES);
   localparam logic [CNT_W-1:0] LAST  = CNT_W'(MUL_CYCLES - 1);

   mul_state_t       state_q, state_d;
   logic [CNT_W-1:0] cnt_q;
   logic [W-1:0]     acc_q, mcand_q, mplier_q, acc_next;
   logic             last;

   assign acc_next = mplier_q[0] ? acc_q + mcand_q : acc_q;
   assign busy     = (state_q == ST_MUL);
   assign last     = (cnt_q == LAST);
   assign done     = busy & en & ~abort & last;
   // the final step's addition is folded in so the product is ready on the last edge
   assign product  = acc_next;

   // state register
   always_ff @(posedge clk or posedge rst) begin
      if (rst) state_q <= ST_IDLE;
      else     state_q <= state_d;
   end

   // next-state: start only from idle; leave on last step or abort
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         ST_IDLE: if (start) state_d = ST_MUL;
         ST_MUL:  if (en && (abort || last)) state_d = ST_IDLE;
         default: state_d = ST_IDLE;
      endcase
   end

   // operand load and shift-add iteration
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt_q    <= '0;
         acc_q    <= '0;
         mcand_q  <= '0;
         mplier_q <= '0;
      end else if (start && !busy) begin
         cnt_q    <= '0;
         acc_q    <= '0;
         mcand_q  <= a;
         mplier_q <= b;
      end else if (busy && en && !abort) begin
         cnt_q    <= cnt_q + 1'b1;
         acc_q    <= acc_next;
         mcand_q  <= mcand_q << 1;
         mplier_q <= mplier_q >> 1;
      end
   end
endmodule

// File: rtl/execute_stage.sv
// Execute stage: operand forwarding, ALU, branch resolve, EX/MEM register.
module execute_stage
   import exec_pkg::*;
#(
   parameter int W          = 24,
   parameter int MUL_CYCLES = W
) (
   input logic            clk,
   input logic            rst,
   execute_stage_if.slave bus
);
   logic [W-1:0] pc, rd1, rd2, rd3, imm;
   logic [W-1:0] op_a, op_b, rd2_fwd, store_data, alu_result, product;
   logic         imm_src, branch_flag, busy, done, mul_start, mul_abort, is_mul;
   logic         unused_fields;
   alu_op_t      op;
   ex_mem_t      alu_bundle, mul_out, lat_q, ex_mem_q;
   logic         branch_taken_q;
   logic [W-1:0] branch_target_q;

   function automatic logic [W-1:0] fwd_mux(input logic [1:0] sel, input logic [W-1:0] bundle,
                                            input logic [W-1:0] mem, input logic [W-1:0] wb);
      case (sel)
         2'd1:    return mem;
         2'd2:    return wb;
         default: return bundle;
      endcase
   endfunction

   // MUL yields 0 here: the real product comes from the iterative unit
   function automatic logic [W-1:0] alu(input alu_op_t f, input logic [W-1:0] a, input logic [W-1:0] b);
      case (f)
         ALU_ADD:   return a + b;
         ALU_SUB:   return a - b;
         ALU_AND:   return a & b;
         ALU_OR:    return a | b;
         ALU_XOR:   return a ^ b;
         ALU_SLL:   return (int'(b[4:0]) >= W) ? '0 : a << b[4:0];
         ALU_SRL:   return (int'(b[4:0]) >= W) ? '0 : a >> b[4:0];
         ALU_PASSB: return b;
         default:   return '0;
      endcase
   endfunction

   assign pc          = bus.bufferIn[PC_LSB  +: W];
   assign rd1         = bus.bufferIn[RD1_LSB +: W];
   assign rd2         = bus.bufferIn[RD2_LSB +: W];
   assign rd3         = bus.bufferIn[RD3_LSB +: W];
   assign imm         = bus.bufferIn[IMM_LSB +: W];
   assign imm_src     = bus.bufferIn[IMM_SRC_BIT];
   assign branch_flag = bus.bufferIn[BRANCH_BIT];
   assign op          = alu_op_t'(bus.bufferIn[ALU_CTRL_LSB +: 4]);
   assign unused_fields = ^{bus.bufferIn[OPTYPE_LSB +: 2], bus.bufferIn[OPCODE_LSB +: 4],
                            bus.bufferIn[RA_LSB +: 4], bus.bufferIn[RB_LSB +: 4]};

   assign op_a       = fwd_mux(bus.fwdSel1, rd1, bus.fwdMem, bus.fwdWb);
   assign rd2_fwd    = fwd_mux(bus.fwdSel2, rd2, bus.fwdMem, bus.fwdWb);
   assign store_data = fwd_mux(bus.fwdSel3, rd3, bus.fwdMem, bus.fwdWb);
   assign op_b       = imm_src ? imm : rd2_fwd;
   assign alu_result = alu(op, op_a, op_b);

   assign is_mul    = (op == ALU_MUL);
   assign mul_start = bus.en & ~bus.flush & ~busy & is_mul;
   assign mul_abort = bus.en & bus.flush;

   // single-cycle result bundle and the product bundle with latched control
   always_comb begin
      alu_bundle.mem_write  = bus.bufferIn[MEM_WRITE_BIT];
      alu_bundle.mem_to_reg = bus.bufferIn[MEM_TO_REG_BIT];
      alu_bundle.reg_write  = bus.bufferIn[REG_WRITE_BIT];
      alu_bundle.rc         = bus.bufferIn[RC_LSB +: 4];
      alu_bundle.alu_result = alu_result;
      alu_bundle.store_data = store_data;
      mul_out               = lat_q;
      mul_out.alu_result    = product;
   end

   shift_add_multiplier #(.W(W), .MUL_CYCLES(MUL_CYCLES)) u_mul (
      .clk     (clk),
      .rst     (rst),
      .en      (bus.en),
      .start   (mul_start),
      .abort   (mul_abort),
      .a       (op_a),
      .b       (op_b),
      .busy    (busy),
      .done    (done),
      .product (product)
   );

   // EX/MEM register; bufferIn is ignored while the multiplier is busy
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         ex_mem_q        <= '0;
         branch_taken_q  <= 1'b0;
         branch_target_q <= '0;
         lat_q           <= '0;
      end else if (bus.en) begin
         if (busy) begin
            ex_mem_q       <= done ? mul_out : '0;
            branch_taken_q <= 1'b0;
         end else begin
            branch_target_q <= pc + imm;
            if (bus.flush || is_mul) begin
               ex_mem_q       <= '0;
               branch_taken_q <= 1'b0;
            end else begin
               ex_mem_q       <= alu_bundle;
               branch_taken_q <= branch_flag & (alu_result == '0);
            end
            if (mul_start) begin
               lat_q            <= alu_bundle;
               lat_q.alu_result <= '0;
            end
         end
      end
   end

   assign bus.stall        = busy;
   assign bus.exMemOut     = ex_mem_q;
   assign bus.branchTaken  = branch_taken_q;
   assign bus.branchTarget = branch_target_q;
endmodule

// File: tb/tb_execute_stage.sv
// Directed bench for execute_stage: vector table plus multi-cycle MUL sequences.
module tb_execute_stage;
   import exec_pkg::*;

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   applied = 0;
   int   errors  = 0;

   execute_stage_if #(.W(24)) bus ();

   execute_stage #(.W(24), .MUL_CYCLES(24)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [146:0] buf_in;
      logic [1:0]   s1, s2, s3;
      logic [23:0]  fm, fw;
      logic         fl;
      logic [54:0]  exp_ex;
      logic         exp_bt;
      logic [23:0]  exp_tgt;
   } vec_t;

   vec_t vecs[$];

   task automatic check(input string name, input logic [54:0] act, input logic [54:0] exp);
      applied++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   function automatic logic [146:0] bundle(input logic [3:0] ctrl, input logic imm_src, input logic bf,
                                           input logic mw, input logic mtr, input logic rw,
                                           input logic [3:0] rc, input logic [23:0] rd1,
                                           input logic [23:0] rd2, input logic [23:0] rd3,
                                           input logic [23:0] imm, input logic [23:0] pc);
      return {pc, 2'b00, 4'h0, imm_src, bf, mw, mtr, rw, ctrl,
              4'h0, rd1, 4'h0, rd2, rc, rd3, imm};
   endfunction

   function automatic logic [54:0] exm(input logic mw, input logic mtr, input logic rw,
                                       input logic [3:0] rc, input logic [23:0] res,
                                       input logic [23:0] store);
      return {mw, mtr, rw, rc, res, store};
   endfunction

   function automatic vec_t mk(input logic [146:0] b, input logic [1:0] s1, input logic [1:0] s2,
                               input logic [1:0] s3, input logic [23:0] fm, input logic [23:0] fw,
                               input logic fl, input logic [54:0] ex, input logic bt,
                               input logic [23:0] tgt);
      vec_t v;
      v.buf_in = b; v.s1 = s1; v.s2 = s2; v.s3 = s3; v.fm = fm; v.fw = fw; v.fl = fl;
      v.exp_ex = ex; v.exp_bt = bt; v.exp_tgt = tgt;
      return v;
   endfunction

   task automatic drive(input vec_t v);
      bus.bufferIn = v.buf_in;
      bus.fwdSel1  = v.s1;
      bus.fwdSel2  = v.s2;
      bus.fwdSel3  = v.s3;
      bus.fwdMem   = v.fm;
      bus.fwdWb    = v.fw;
      bus.flush    = v.fl;
   endtask

   task automatic apply(input vec_t v, input string tag);
      drive(v);
      @(posedge clk); #1;
      check({tag, "_exmem"},  bus.exMemOut,     v.exp_ex);
      check({tag, "_taken"},  bus.branchTaken,  v.exp_bt);
      check({tag, "_target"}, bus.branchTarget, v.exp_tgt);
   endtask

   task automatic mul_seq(input string tag, input logic [23:0] a, input logic [23:0] b,
                          input logic bf, input int hold_at, input int hold_len,
                          input logic [23:0] exp_prod, input int exp_cycles);
      int n;
      bus.flush    = 1'b0;
      bus.fwdSel1  = 2'd0;
      bus.fwdSel2  = 2'd0;
      bus.fwdSel3  = 2'd0;
      bus.en       = 1'b1;
      bus.bufferIn = bundle(4'd7, 1'b0, bf, 1'b0, 1'b0, 1'b1, 4'd5, a, b, 24'h000055, 24'h0, 24'h0);
      @(posedge clk); #1;
      check({tag, "_accept_stall"},  bus.stall,    1);
      check({tag, "_accept_bubble"}, bus.exMemOut, 0);
      bus.bufferIn = bundle(4'd0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 4'd15, 24'h3, 24'h4, 24'h9, 24'h0, 24'h0);
      n = 0;
      while (bus.stall && n < 100) begin
         if (n == hold_at) bus.en = 1'b0;
         if (n == hold_at + hold_len) bus.en = 1'b1;
         @(posedge clk); #1;
         n++;
         if (bus.stall) check({tag, "_bubble"}, bus.exMemOut, 0);
      end
      bus.en = 1'b1;
      check({tag, "_stall_cycles"}, n, exp_cycles);
      check({tag, "_product"}, bus.exMemOut, exm(1'b0, 1'b0, 1'b1, 4'd5, exp_prod, 24'h000055));
      check({tag, "_taken"},   bus.branchTaken, 0);
   endtask

   initial begin
      vec_t zero_v;
      bus.en = 1'b0; bus.flush = 1'b0; bus.bufferIn = '0;
      bus.fwdSel1 = 2'd0; bus.fwdSel2 = 2'd0; bus.fwdSel3 = 2'd0;
      bus.fwdMem = '0; bus.fwdWb = '0;

      // ctrl, immSrc, bf, mw, mtr, rw, rc, rd1, rd2, rd3, imm, pc
      vecs.push_back(mk(bundle(4'd0, 0, 0, 0, 0, 1, 4'd4, 24'h5, 24'h3, 24'h0, 24'h0, 24'h0),
                        0, 0, 0, 0, 0, 0, exm(0, 0, 1, 4'd4, 24'h000008, 0), 0, 24'h0));
      vecs.push_back(mk(bundle(4'd1, 1, 0, 0, 0, 1, 4'd2, 24'h10, 24'h999, 24'h0, 24'hFFFFFF, 24'h0),
                        0, 0, 0, 0, 0, 0, exm(0, 0, 1, 4'd2, 24'h000011, 0), 0, 24'hFFFFFF));
      vecs.push_back(mk(bundle(4'd5, 1, 0, 0, 0, 1, 4'd3, 24'h1, 24'h0, 24'h0, 24'd30, 24'h0),
                        0, 0, 0, 0, 0, 0, exm(0, 0, 1, 4'd3, 24'h0, 0), 0, 24'd30));
      vecs.push_back(mk(bundle(4'd5, 0, 0, 0, 0, 1, 4'd3, 24'h123, 24'h4, 24'h0, 24'h0, 24'h10),
                        0, 0, 0, 0, 0, 0, exm(0, 0, 1, 4'd3, 24'h001230, 0), 0, 24'h10));
      vecs.push_back(mk(bundle(4'd6, 1, 0, 0, 0, 1, 4'd1, 24'h800000, 24'h0, 24'h0, 24'd23, 24'h0),
                        0, 0, 0, 0, 0, 0, exm(0, 0, 1, 4'd1, 24'h000001, 0), 0, 24'd23));
      vecs.push_back(mk(bundle(4'd2, 0, 0, 0, 0, 1, 4'd6, 24'hF0F0F0, 24'h0FF0FF, 24'h0, 24'h0, 24'h0),
                        0, 0, 0, 0, 0, 0, exm(0, 0, 1, 4'd6, 24'h00F0F0, 0), 0, 24'h0));
      vecs.push_back(mk(bundle(4'd3, 0, 0, 0, 0, 1, 4'd6, 24'hF0F0F0, 24'h0FF0FF, 24'h0, 24'h0, 24'h0),
                        0, 0, 0, 0, 0, 0, exm(0, 0, 1, 4'd6, 24'hFFF0FF, 0), 0, 24'h0));
      vecs.push_back(mk(bundle(4'd4, 0, 0, 0, 0, 1, 4'd6, 24'hF0F0F0, 24'h0FF0FF, 24'h0, 24'h0, 24'h0),
                        0, 0, 0, 0, 0, 0, exm(0, 0, 1, 4'd6, 24'hFF000F, 0), 0, 24'h0));
      vecs.push_back(mk(bundle(4'd8, 1, 0, 0, 0, 1, 4'd8, 24'h777, 24'h0, 24'h0, 24'h00ABCD, 24'h0),
                        0, 0, 0, 0, 0, 0, exm(0, 0, 1, 4'd8, 24'h00ABCD, 0), 0, 24'h00ABCD));
      vecs.push_back(mk(bundle(4'd12, 0, 0, 0, 0, 1, 4'd2, 24'h5, 24'h3, 24'h0, 24'h0, 24'h0),
                        0, 0, 0, 0, 0, 0, exm(0, 0, 1, 4'd2, 24'h0, 0), 0, 24'h0));
      vecs.push_back(mk(bundle(4'd1, 0, 1, 0, 0, 0, 4'd0, 24'h7, 24'h7, 24'h0, 24'h20, 24'h100),
                        0, 0, 0, 0, 0, 0, exm(0, 0, 0, 4'd0, 24'h0, 0), 1, 24'h000120));
      vecs.push_back(mk(bundle(4'd1, 0, 1, 0, 0, 0, 4'd0, 24'h7, 24'h6, 24'h0, 24'h20, 24'h100),
                        0, 0, 0, 0, 0, 0, exm(0, 0, 0, 4'd0, 24'h1, 0), 0, 24'h000120));
      vecs.push_back(mk(bundle(4'd0, 0, 0, 0, 0, 1, 4'd9, 24'h111, 24'h222, 24'h333, 24'h0, 24'h0),
                        2'd1, 2'd2, 2'd0, 24'h0000AA, 24'h000001, 0,
                        exm(0, 0, 1, 4'd9, 24'h0000AB, 24'h333), 0, 24'h0));
      vecs.push_back(mk(bundle(4'd0, 1, 0, 1, 0, 0, 4'd0, 24'h40, 24'h0, 24'h333, 24'h4, 24'h0),
                        2'd3, 2'd0, 2'd1, 24'h0005A5, 24'h0, 0,
                        exm(1, 0, 0, 4'd0, 24'h000044, 24'h0005A5), 0, 24'h4));
      vecs.push_back(mk(bundle(4'd0, 1, 0, 0, 1, 1, 4'd7, 24'h1, 24'h0, 24'h0, 24'h8, 24'h0),
                        2'd2, 2'd0, 2'd0, 24'h0, 24'h000100, 0,
                        exm(0, 1, 1, 4'd7, 24'h000108, 0), 0, 24'h8));
      vecs.push_back(mk(bundle(4'd0, 0, 0, 0, 0, 1, 4'd4, 24'h5, 24'h3, 24'h0, 24'h10, 24'h200),
                        0, 0, 0, 0, 0, 1, exm(0, 0, 0, 4'd0, 24'h0, 0), 0, 24'h000210));
      zero_v = mk('0, 0, 0, 0, 0, 0, 0, '0, 0, 24'h0);

      #12;
      check("reset_exmem",  bus.exMemOut,     0);
      check("reset_taken",  bus.branchTaken,  0);
      check("reset_target", bus.branchTarget, 0);
      check("reset_stall",  bus.stall,        0);
      @(negedge clk);
      rst    = 1'b0;
      bus.en = 1'b1;

      foreach (vecs[i]) apply(vecs[i], $sformatf("vec%0d", i));

      // en low with flush: no effect, output holds the previous result
      apply(vecs[0], "pre_hold");
      bus.en = 1'b0;
      drive(vecs[4]);
      bus.flush = 1'b1;
      @(posedge clk); #1;
      check("en_low_hold", bus.exMemOut, vecs[0].exp_ex);
      bus.flush = 1'b0;
      bus.en    = 1'b1;

      mul_seq("mul_basic", 24'h000123, 24'h000010, 1'b0, -1, 0, 24'h001230, 24);
      mul_seq("mul_ovf",   24'h800000, 24'h000002, 1'b1, -1, 0, 24'h000000, 24);
      mul_seq("mul_hold",  24'h000123, 24'h000010, 1'b0, 10, 5, 24'h001230, 29);

      // reset during iteration 10
      bus.bufferIn = bundle(4'd7, 0, 0, 0, 0, 1, 4'd5, 24'h123, 24'h10, 24'h55, 24'h0, 24'h50);
      @(posedge clk); #1;
      repeat (10) @(posedge clk);
      #1;
      check("rst_mid_busy", bus.stall, 1);
      #2 rst = 1'b1;
      #1;
      check("rst_mid_stall",  bus.stall,        0);
      check("rst_mid_exmem",  bus.exMemOut,     0);
      check("rst_mid_taken",  bus.branchTaken,  0);
      check("rst_mid_target", bus.branchTarget, 0);
      @(negedge clk);
      rst = 1'b0;
      apply(vecs[0], "post_rst_add");

      // flush during MUL: bubble and no product afterwards
      bus.bufferIn = bundle(4'd7, 0, 0, 0, 0, 1, 4'd5, 24'h123, 24'h10, 24'h55, 24'h0, 24'h0);
      @(posedge clk); #1;
      repeat (5) @(posedge clk);
      #1;
      bus.flush = 1'b1;
      @(posedge clk); #1;
      check("flush_mul_stall", bus.stall,    0);
      check("flush_mul_exmem", bus.exMemOut, 0);
      drive(zero_v);
      for (int k = 0; k < 30; k++) begin
         @(posedge clk); #1;
         check("flush_no_product", bus.exMemOut, 0);
      end

      $display("== %0d vectors applied, %0d miscompares ==", applied, errors);
      $finish;
   end
endmodule
